// File: rtl/stage_cordic_postscale.sv
// CORDIC post-scale: round Q10.8 offset, add reference point, clamp (STAGE_POSTSCALE_CLAMP_EN) or wrap; 2-cycle latency.
// Two-register pipeline with bubble compaction; in_ready depends combinationally on out_ready.
module stage_cordic_postscale #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_bubble,
  output logic        in_ready,
  input  logic [18:0] cord_x,
  input  logic [18:0] cord_y,
  input  logic        in_enabel_cordic,
  input  logic        in_form,
  input  logic [8:0]  in_color,
  input  logic [9:0]  in_pixel_x,
  input  logic [9:0]  in_pixel_y,
  input  logic [8:0]  in_ref_point_x,
  input  logic [8:0]  in_ref_point_y,
  input  logic [8:0]  in_angle,
  input  logic        out_ready,
  output logic        out_bubble,
  output logic [9:0]  out_vertex_x,
  output logic [9:0]  out_vertex_y,
  output logic [10:0] out_dx,
  output logic [10:0] out_dy,
  output logic        out_clamped,
  output logic        out_form,
  output logic [8:0]  out_color,
  output logic [9:0]  out_pixel_x,
  output logic [9:0]  out_pixel_y,
  output logic [8:0]  out_angle,
  output logic        out_enabel_cordic
);

  localparam logic signed [11:0] X_LIM = 12'(SCREEN_W);
  localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H);

  logic s1_full, s2_full;
  logic s1_adv, s2_adv;

  logic signed [11:0] s1_sx, s1_sy;
  logic [9:0]  s1_px, s1_py;
  logic        s1_form, s1_en;
  logic [8:0]  s1_color, s1_angle;

  logic [9:0]  s2_vx, s2_vy, s2_px, s2_py;
  logic [10:0] s2_dx, s2_dy;
  logic        s2_clamped, s2_form, s2_en;
  logic [8:0]  s2_color, s2_angle;

  logic signed [11:0] sum_x, sum_y;
  logic [9:0]  vx_nxt, vy_nxt;
  logic [10:0] dx_nxt, dy_nxt;
  logic        clamp_nxt;

  // Round half toward +inf, keep 11 signed integer bits, then add the unsigned reference.
  function automatic logic signed [11:0] round_sum(input logic [18:0] cord, input logic [8:0] refp);
    logic [19:0] t;
    logic [10:0] r;
    t = {cord[18], cord} + 20'd128;
    r = t[18:8];
    return $signed({r[10], r}) + $signed({3'b000, refp});
  endfunction

  assign s2_adv   = !s2_full || out_ready;
  assign s1_adv   = !s1_full || s2_adv;
  assign in_ready = s1_adv;

  assign sum_x = round_sum(cord_x, in_ref_point_x);
  assign sum_y = round_sum(cord_y, in_ref_point_y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_full <= 1'b0;
      s2_full <= 1'b0;
    end else begin
      if (s1_adv) s1_full <= !in_bubble;
      if (s2_adv) s2_full <= s1_full;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_sx    <= sum_x;
      s1_sy    <= sum_y;
      s1_px    <= in_pixel_x;
      s1_py    <= in_pixel_y;
      s1_form  <= in_form;
      s1_en    <= in_enabel_cordic;
      s1_color <= in_color;
      s1_angle <= in_angle;
    end
  end

  always_comb begin
    vx_nxt    = s1_sx[9:0];
    vy_nxt    = s1_sy[9:0];
    clamp_nxt = 1'b0;
`ifdef STAGE_POSTSCALE_CLAMP_EN
    if (s1_sx < 0) begin
      vx_nxt    = '0;
      clamp_nxt = 1'b1;
    end else if (s1_sx >= X_LIM) begin
      vx_nxt    = 10'(X_LIM - 12'sd1);
      clamp_nxt = 1'b1;
    end
    if (s1_sy < 0) begin
      vy_nxt    = '0;
      clamp_nxt = 1'b1;
    end else if (s1_sy >= Y_LIM) begin
      vy_nxt    = 10'(Y_LIM - 12'sd1);
      clamp_nxt = 1'b1;
    end
`endif
    dx_nxt = {1'b0, s1_px} - {1'b0, vx_nxt};
    dy_nxt = {1'b0, s1_py} - {1'b0, vy_nxt};
  end

`ifndef STAGE_POSTSCALE_CLAMP_EN
  // Wrap mode only looks at the low 10 bits of the sum.
  logic unused_wrap_bits;
  assign unused_wrap_bits = ^{s1_sx[11:10], s1_sy[11:10], X_LIM[0], Y_LIM[0]};
`endif

  always_ff @(posedge clk) begin
    if (s2_adv) begin
      s2_vx      <= vx_nxt;
      s2_vy      <= vy_nxt;
      s2_dx      <= dx_nxt;
      s2_dy      <= dy_nxt;
      s2_clamped <= clamp_nxt;
      s2_px      <= s1_px;
      s2_py      <= s1_py;
      s2_form    <= s1_form;
      s2_en      <= s1_en;
      s2_color   <= s1_color;
      s2_angle   <= s1_angle;
    end
  end

  assign out_bubble        = !s2_full;
  assign out_vertex_x      = s2_vx;
  assign out_vertex_y      = s2_vy;
  assign out_dx            = s2_dx;
  assign out_dy            = s2_dy;
  assign out_clamped       = s2_clamped;
  assign out_form          = s2_form;
  assign out_color         = s2_color;
  assign out_pixel_x       = s2_px;
  assign out_pixel_y       = s2_py;
  assign out_angle         = s2_angle;
  assign out_enabel_cordic = s2_en;

endmodule

// File: tb/tb_stage_cordic_postscale.sv
// Directed bench for stage_cordic_postscale; expected values are hand-computed constants.
module tb_stage_cordic_postscale;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_bubble;
  logic        in_ready;
  logic [18:0] cord_x, cord_y;
  logic        in_enabel_cordic, in_form;
  logic [8:0]  in_color;
  logic [9:0]  in_pixel_x, in_pixel_y;
  logic [8:0]  in_ref_point_x, in_ref_point_y;
  logic [8:0]  in_angle;
  logic        out_ready;
  logic        out_bubble;
  logic [9:0]  out_vertex_x, out_vertex_y;
  logic [10:0] out_dx, out_dy;
  logic        out_clamped, out_form;
  logic [8:0]  out_color;
  logic [9:0]  out_pixel_x, out_pixel_y;
  logic [8:0]  out_angle;
  logic        out_enabel_cordic;

  int checks = 0;
  int errors = 0;

`ifdef STAGE_POSTSCALE_CLAMP_EN
  localparam int EXP_HI = 639;
  localparam int EXP_LO = 0;
  localparam int EXP_CL = 1;
`else
  localparam int EXP_HI = 700;
  localparam int EXP_LO = 1014;
  localparam int EXP_CL = 0;
`endif

  stage_cordic_postscale dut (
    .clk(clk), .reset(reset), .in_bubble(in_bubble), .in_ready(in_ready),
    .cord_x(cord_x), .cord_y(cord_y), .in_enabel_cordic(in_enabel_cordic),
    .in_form(in_form), .in_color(in_color), .in_pixel_x(in_pixel_x),
    .in_pixel_y(in_pixel_y), .in_ref_point_x(in_ref_point_x),
    .in_ref_point_y(in_ref_point_y), .in_angle(in_angle), .out_ready(out_ready),
    .out_bubble(out_bubble), .out_vertex_x(out_vertex_x), .out_vertex_y(out_vertex_y),
    .out_dx(out_dx), .out_dy(out_dy), .out_clamped(out_clamped), .out_form(out_form),
    .out_color(out_color), .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y),
    .out_angle(out_angle), .out_enabel_cordic(out_enabel_cordic)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [18:0] cx, input logic [18:0] cy,
                       input logic [8:0] rx, input logic [8:0] ry,
                       input logic [9:0] px, input logic [9:0] py, input logic [8:0] tag);
    in_bubble        = 1'b0;
    cord_x           = cx;
    cord_y           = cy;
    in_ref_point_x   = rx;
    in_ref_point_y   = ry;
    in_pixel_x       = px;
    in_pixel_y       = py;
    in_color         = tag;
    in_angle         = ~tag;
    in_form          = tag[0];
    in_enabel_cordic = tag[1];
  endtask

  initial begin
    reset = 1'b0; in_bubble = 1'b1; out_ready = 1'b1;
    drive(19'd0, 19'd0, 9'd0, 9'd0, 10'd0, 10'd0, 9'd0);
    in_bubble = 1'b1;
    #1;
    check("reset_out_bubble", out_bubble, 1);
    check("reset_in_ready", in_ready, 1);
    step(); step();
    reset = 1'b1;

    // basic item
    drive(19'd2560, 19'(-896), 9'd100, 9'd50, 10'd120, 10'd40, 9'd1);
    step();
    in_bubble = 1'b1;
    check("lat_not_yet", out_bubble, 1);
    step();
    check("basic_valid", out_bubble, 0);
    check("basic_vx", out_vertex_x, 110);
    check("basic_vy", out_vertex_y, 47);
    check("basic_dx", $signed(out_dx), 10);
    check("basic_dy", $signed(out_dy), -7);
    check("basic_clamped", out_clamped, 0);
    check("basic_color", out_color, 1);
    check("basic_angle", out_angle, 9'h1FE);
    check("basic_pixel_x", out_pixel_x, 120);
    check("basic_pixel_y", out_pixel_y, 40);
    check("basic_form", out_form, 1);
    check("basic_en", out_enabel_cordic, 0);
    step();
    check("basic_drained", out_bubble, 1);

    // rounding at the half points
    drive(19'd128, 19'd0, 9'd20, 9'd0, 10'd0, 10'd0, 9'd2);
    step();
    drive(19'(-129), 19'd0, 9'd20, 9'd0, 10'd0, 10'd0, 9'd3);
    step();
    in_bubble = 1'b1;
    check("round_up_vx", out_vertex_x, 21);
    step();
    check("round_dn_vx", out_vertex_x, 19);
    step();

    // out-of-screen results
    drive(19'd51200, 19'd0, 9'd500, 9'd0, 10'd0, 10'd0, 9'd4);
    step();
    drive(19'(-5120), 19'd0, 9'd10, 9'd0, 10'd0, 10'd0, 9'd5);
    step();
    in_bubble = 1'b1;
    check("hi_vx", out_vertex_x, EXP_HI);
    check("hi_clamped", out_clamped, EXP_CL);
    check("hi_dx", $signed(out_dx), -EXP_HI);
    step();
    check("lo_vx", out_vertex_x, EXP_LO);
    check("lo_clamped", out_clamped, EXP_CL);
    check("lo_dx", $signed(out_dx), -EXP_LO);
    step();

    // back-pressure with four items
    drive(19'd0, 19'd0, 9'd200, 9'd0, 10'd0, 10'd0, 9'd6);
    step();
    drive(19'd0, 19'd0, 9'd201, 9'd0, 10'd0, 10'd0, 9'd7);
    step();
    out_ready = 1'b0;
    drive(19'd0, 19'd0, 9'd202, 9'd0, 10'd0, 10'd0, 9'd8);
    #1;
    check("stall_in_ready", in_ready, 0);
    check("stall_head", out_color, 6);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_hold_color", out_color, 6);
      check("stall_hold_vx", out_vertex_x, 200);
      check("stall_hold_valid", out_bubble, 0);
      check("stall_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", in_ready, 1);
    step();
    check("order_1", out_color, 7);
    check("order_1_vx", out_vertex_x, 201);
    drive(19'd0, 19'd0, 9'd203, 9'd0, 10'd0, 10'd0, 9'd9);
    step();
    check("order_2", out_color, 8);
    in_bubble = 1'b1;
    step();
    check("order_3", out_color, 9);
    check("order_3_vx", out_vertex_x, 203);
    step();
    check("order_drained", out_bubble, 1);

    // bubble compaction under stall
    out_ready = 1'b0;
    in_bubble = 1'b1;
    step();
    drive(19'd0, 19'd0, 9'd210, 9'd0, 10'd0, 10'd0, 9'd10);
    step();
    in_bubble = 1'b1;
    check("compact_s1_only", out_bubble, 1);
    step();
    check("compact_valid", out_bubble, 0);
    check("compact_color", out_color, 10);
    drive(19'd0, 19'd0, 9'd211, 9'd0, 10'd0, 10'd0, 9'd11);
    step();
    in_bubble = 1'b1;
    check("compact_hold", out_color, 10);
    #1;
    check("compact_full_ready", in_ready, 0);
    step();
    check("compact_hold2", out_color, 10);
    out_ready = 1'b1;
    step();
    check("compact_next", out_color, 11);
    step();
    check("compact_no_bubble_out", out_bubble, 1);

    // reset with two items in flight
    drive(19'd0, 19'd0, 9'd220, 9'd0, 10'd0, 10'd0, 9'd12);
    step();
    drive(19'd0, 19'd0, 9'd221, 9'd0, 10'd0, 10'd0, 9'd13);
    step();
    check("pre_reset_valid", out_bubble, 0);
    reset = 1'b0;
    #1;
    check("midreset_bubble", out_bubble, 1);
    check("midreset_ready", in_ready, 1);
    in_bubble = 1'b1;
    step(); step();
    check("held_reset_bubble", out_bubble, 1);
    reset = 1'b1;
    drive(19'd0, 19'd0, 9'd50, 9'd60, 10'd0, 10'd0, 9'd14);
    step();
    in_bubble = 1'b1;
    check("post_reset_lat", out_bubble, 1);
    step();
    check("post_reset_valid", out_bubble, 0);
    check("post_reset_vx", out_vertex_x, 50);
    check("post_reset_vy", out_vertex_y, 60);
    check("post_reset_color", out_color, 14);
    step();
    check("post_reset_drained", out_bubble, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
